// File: rtl/imem_fetch.sv
// imem_fetch: read sequencer for the banked PE instruction memory; IMEM_FETCH_LOOP_EN adds multi-pass replay
module imem_fetch #(
    parameter int INST_WIDTH = 64,
    parameter int INST_WORD  = 32,
    localparam int AW = $clog2(INST_WORD),
    localparam int LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LW-1:0]         len_i,
    input  logic                  flush_i,
`ifdef IMEM_FETCH_LOOP_EN
    input  logic [7:0]            loop_cnt_i,
`endif
    output logic [AW-1:0]         addr_r_o,
    output logic                  cen_r_o,
    output logic                  gwen_r_o,
    output logic                  r_switch_o,
    input  logic [INST_WIDTH-1:0] imem_data_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWITCH} state_t;
    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         hold_q, hold_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [INST_WIDTH-1:0] mem_q [2];
    logic [INST_WIDTH-1:0] mem_d [2];
`ifdef IMEM_FETCH_LOOP_EN
    logic [7:0]            pass_q, pass_d;
`endif
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic                  more_pass;
    logic                  launch;
    logic [2:0]            room;
    logic [AW-1:0]         last_addr;
    logic [LW-1:0]         len_clamp;

    // issue only while buffer occupancy plus the read in flight, net of this cycle's pop, leaves a free slot
    always_comb begin
        pop        = (cnt_q != 2'd0) && inst_ready_i;
        room       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == FETCH) && (room < 3'd2);
        last_addr  = AW'(len_q - LW'(1));
        last_issue = issue && (addr_q == last_addr);
        launch     = (state_q == IDLE) && start_i && !flush_i;
        len_clamp  = (len_i > LW'(INST_WORD)) ? LW'(INST_WORD) : len_i;
`ifdef IMEM_FETCH_LOOP_EN
        more_pass  = pass_q != 8'd0;
`else
        more_pass  = 1'b0;
`endif
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next state; flush wins over everything, including a pending launch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = (len_i == '0) ? SWITCH : FETCH;
            FETCH:   if (last_issue && !more_pass) state_d = DRAIN;
            DRAIN:   if (cnt_q == {1'b0, pop} && !inflight_q) state_d = SWITCH;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // outputs; address holds its last issued value while no read is issued
    always_comb begin
        cen_r_o      = ~issue;
        addr_r_o     = issue ? addr_q : hold_q;
        gwen_r_o     = 1'b1;
        r_switch_o   = state_q == SWITCH;
        done_o       = r_switch_o;
        busy_o       = state_q != IDLE;
        inst_valid_o = cnt_q != 2'd0;
        inst_o       = mem_q[rd_q];
    end

    // address walk, in-flight tracking and the 2-entry output FIFO
    always_comb begin
        addr_d     = addr_q;
        hold_d     = addr_r_o;
        len_d      = len_q;
        inflight_d = issue & ~flush_i;
        cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        rd_d       = rd_q ^ pop;
        wr_d       = wr_q ^ inflight_q;
        mem_d      = mem_q;
        if (inflight_q) mem_d[wr_q] = imem_data_i;
`ifdef IMEM_FETCH_LOOP_EN
        pass_d     = pass_q;
`endif
        if (launch) begin
            addr_d = '0;
            hold_d = '0;
            len_d  = len_clamp;
`ifdef IMEM_FETCH_LOOP_EN
            pass_d = loop_cnt_i;
`endif
        end
        if (issue) begin
            addr_d = last_issue ? '0 : addr_q + 1'b1;
`ifdef IMEM_FETCH_LOOP_EN
            if (last_issue && more_pass) pass_d = pass_q - 8'd1;
`endif
        end
        if (flush_i) begin
            cnt_d = '0;
            rd_d  = 1'b0;
            wr_d  = 1'b0;
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            hold_q     <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            mem_q      <= '{default: '0};
`ifdef IMEM_FETCH_LOOP_EN
            pass_q     <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            mem_q      <= mem_d;
`ifdef IMEM_FETCH_LOOP_EN
            pass_q     <= pass_d;
`endif
        end
    end
endmodule
